// File: rtl/load_store_unit_if.sv
// Request/response bus between the processor datapath (master) and the
// load/store unit (slave).
// Handshake: a request transfers on a posedge where req_valid && req_ready;
// req_ready is independent of req_valid, and all request fields are only
// meaningful while req_valid is high. resp_valid is a one-cycle pulse with
// no back-pressure; resp_err and resp_rdata are qualified by it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-only memory with
// combinational read; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_writeData,
  output logic                mem_writeEnable,
  input  logic [31:0]         mem_read,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_t      state, state_next;
  logic        l_write;
  logic [1:0]  l_size;
  logic        l_signed;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_err;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic        sub_word_store;
  logic [31:0] word_addr;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept         = bus.req_valid && (state == IDLE);
  assign sub_word_store = l_write && (l_size != 2'd2);
  assign word_addr      = {l_addr[31:2], 2'b00};

  assign req_err = (bus.req_size == 2'd3)
                || (bus.req_size == 2'd1 && bus.req_addr[0])
                || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
                || ({1'b0, bus.req_addr} >= ADDR_LIMIT);

  // Little-endian lane extraction from the addressed word
  assign lane_byte = mem_read[{l_addr[1:0], 3'b000} +: 8];
  assign lane_half = l_addr[1] ? mem_read[31:16] : mem_read[15:0];

  always_comb begin
    load_val = mem_read;
    case (l_size)
      2'd0:    load_val = {{24{l_signed & lane_byte[7]}}, lane_byte};
      2'd1:    load_val = {{16{l_signed & lane_half[15]}}, lane_half};
      default: load_val = mem_read;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (l_size == 2'd0)
      merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
    else if (l_addr[1])
      merged[31:16] = l_wdata[15:0];
    else
      merged[15:0] = l_wdata[15:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = sub_word_store ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write strobe is masked by reset so an aborted request never touches memory
  always_comb begin
    mem_addr        = 32'd0;
    mem_writeData   = 32'd0;
    mem_writeEnable = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr = word_addr;
        if (l_write && l_size == 2'd2) begin
          mem_writeData   = l_wdata;
          mem_writeEnable = !reset;
        end
      end
      WRITE: begin
        mem_addr        = word_addr;
        mem_writeData   = merged;
        mem_writeEnable = !reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      l_write  <= 1'b0;
      l_size   <= 2'd0;
      l_signed <= 1'b0;
      l_addr   <= 32'd0;
      l_wdata  <= 32'd0;
      l_err    <= 1'b0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        l_write  <= bus.req_write;
        l_size   <= bus.req_size;
        l_signed <= bus.req_signed;
        l_addr   <= bus.req_addr;
        l_wdata  <= bus.req_wdata;
        l_err    <= req_err;
      end
      if (state == ACCESS && sub_word_store)
        merge_q <= mem_read;
      // Response data changes only when a response is issued, then holds
      if (state_next == RESP)
        rdata_q <= (state == ACCESS && !l_write) ? load_val : 32'd0;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && l_err;
  assign bus.resp_rdata = rdata_q;
  assign dbg_state      = state;

endmodule
